// File: rtl/card_pkg.sv
// Shared card encodings for the display auditor: rank enum, segment
// patterns (active-low {g,f,e,d,c,b,a}), FSM state enum and scoring helpers.
package card_pkg;

  typedef enum logic [3:0] {
    RANK_BLANK = 4'd0,
    RANK_ACE   = 4'd1,
    RANK_TWO   = 4'd2,
    RANK_THREE = 4'd3,
    RANK_FOUR  = 4'd4,
    RANK_FIVE  = 4'd5,
    RANK_SIX   = 4'd6,
    RANK_SEVEN = 4'd7,
    RANK_EIGHT = 4'd8,
    RANK_NINE  = 4'd9,
    RANK_TEN   = 4'd10,
    RANK_JACK  = 4'd11,
    RANK_QUEEN = 4'd12,
    RANK_KING  = 4'd13
  } card_rank_e;

  localparam logic [6:0] SEG_ACE   = 7'b0001000;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;
  localparam logic [6:0] SEG_THREE = 7'b0110000;
  localparam logic [6:0] SEG_FOUR  = 7'b0011001;
  localparam logic [6:0] SEG_FIVE  = 7'b0010010;
  localparam logic [6:0] SEG_SIX   = 7'b0000010;
  localparam logic [6:0] SEG_SEVEN = 7'b1111000;
  localparam logic [6:0] SEG_EIGHT = 7'b0000000;
  localparam logic [6:0] SEG_NINE  = 7'b0010000;
  localparam logic [6:0] SEG_TEN   = 7'b1000000;
  localparam logic [6:0] SEG_JACK  = 7'b1100001;
  localparam logic [6:0] SEG_QUEEN = 7'b0011000;
  localparam logic [6:0] SEG_KING  = 7'b0001001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCORE  = 2'd2,
    ST_REPORT = 2'd3
  } aud_state_e;

  // Baccarat point value: pips score face value, blank and ten/face score 0.
  function automatic logic [3:0] card_value(input card_rank_e r);
    return (r >= RANK_ACE && r <= RANK_NINE) ? 4'(r) : 4'd0;
  endfunction

  // Three-card sums never exceed 27, so two compare/subtract steps give mod 10.
  function automatic logic [4:0] mod10_27(input logic [4:0] a);
    if (a >= 5'd20)      return a - 5'd20;
    else if (a >= 5'd10) return a - 5'd10;
    else                 return a;
  endfunction

endpackage

// File: rtl/seg7_to_card.sv
// Combinational decode of one active-low 7-segment pattern to a card rank.
module seg7_to_card
  import card_pkg::*;
(
  input  logic [6:0] seg,
  output card_rank_e rank,
  output logic       valid
);

  // Table lookup; unknown patterns decode to blank rank and flag invalid.
  always_comb begin
    rank  = RANK_BLANK;
    valid = 1'b1;
    case (seg)
      SEG_ACE:   rank = RANK_ACE;
      SEG_TWO:   rank = RANK_TWO;
      SEG_THREE: rank = RANK_THREE;
      SEG_FOUR:  rank = RANK_FOUR;
      SEG_FIVE:  rank = RANK_FIVE;
      SEG_SIX:   rank = RANK_SIX;
      SEG_SEVEN: rank = RANK_SEVEN;
      SEG_EIGHT: rank = RANK_EIGHT;
      SEG_NINE:  rank = RANK_NINE;
      SEG_TEN:   rank = RANK_TEN;
      SEG_JACK:  rank = RANK_JACK;
      SEG_QUEEN: rank = RANK_QUEEN;
      SEG_KING:  rank = RANK_KING;
      SEG_BLANK: rank = RANK_BLANK;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/hand_display_auditor.sv
// Display-level auditor: snapshots HEX0..5 and LEDR, decodes one digit per
// cycle, recomputes baccarat scores/winner and flags disagreement with LEDR.
module hand_display_auditor
  import card_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [6:0]            HEX0,
  input  logic [6:0]            HEX1,
  input  logic [6:0]            HEX2,
  input  logic [6:0]            HEX3,
  input  logic [6:0]            HEX4,
  input  logic [6:0]            HEX5,
  input  logic [9:0]            LEDR_in,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            player_score,
  output logic [3:0]            dealer_score,
  output logic                  player_win,
  output logic                  dealer_win,
  output logic [NUM_DIGITS-1:0] invalid_mask,
  output logic                  mismatch
);

  aud_state_e            state_q, state_d;
  logic [6:0]            hex_q [NUM_DIGITS];
  logic [6:0]            hex_d [NUM_DIGITS];
  logic [9:0]            ledr_q, ledr_d;
  logic [2:0]            idx_q, idx_d;
  logic [4:0]            p_acc_q, p_acc_d, d_acc_q, d_acc_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [3:0]            ps_q, ps_d, ds_q, ds_d;
  logic                  pw_q, pw_d, dw_q, dw_d, mm_q, mm_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;

  logic [6:0]            cur_seg;
  card_rank_e            cur_rank;
  logic                  cur_valid;
  logic                  cur_invalid;
  logic [3:0]            cur_val;

  // Select the captured digit addressed by the decode index.
  always_comb begin
    cur_seg = SEG_BLANK;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (idx_q == 3'(i)) cur_seg = hex_q[i];
  end

  seg7_to_card u_dec (
    .seg   (cur_seg),
    .rank  (cur_rank),
    .valid (cur_valid)
  );

  // Blank is only a legal display on the third-card digits (HEX2, HEX5).
  always_comb begin
    cur_val     = card_value(cur_rank);
    cur_invalid = !cur_valid ||
                  (cur_rank == RANK_BLANK && !(idx_q == 3'd2 || idx_q == 3'd5));
  end

  // Next-state and datapath updates for IDLE -> DECODE -> SCORE -> REPORT.
  always_comb begin
    state_d = state_q;
    hex_d   = hex_q;
    ledr_d  = ledr_q;
    idx_d   = idx_q;
    p_acc_d = p_acc_q;
    d_acc_d = d_acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ps_d    = ps_q;
    ds_d    = ds_q;
    pw_d    = pw_q;
    dw_d    = dw_q;
    mm_d    = mm_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hex_d[0] = HEX0;
          hex_d[1] = HEX1;
          hex_d[2] = HEX2;
          hex_d[3] = HEX3;
          hex_d[4] = HEX4;
          hex_d[5] = HEX5;
          ledr_d   = LEDR_in;
          idx_d    = '0;
          p_acc_d  = '0;
          d_acc_d  = '0;
          busy_d   = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (idx_q < 3'd3) p_acc_d = p_acc_q + {1'b0, cur_val};
        else              d_acc_d = d_acc_q + {1'b0, cur_val};
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
          if (idx_q == 3'(i)) mask_d[i] = cur_invalid;
        if (idx_q == 3'(NUM_DIGITS - 1)) state_d = ST_SCORE;
        else                             idx_d   = idx_q + 3'd1;
      end
      ST_SCORE: begin
        p_acc_d = mod10_27(p_acc_q);
        d_acc_d = mod10_27(d_acc_q);
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        ps_d    = p_acc_q[3:0];
        ds_d    = d_acc_q[3:0];
        pw_d    = (p_acc_q >= d_acc_q);
        dw_d    = (d_acc_q >= p_acc_q);
        mm_d    = (ledr_q != {(d_acc_q >= p_acc_q), (p_acc_q >= d_acc_q),
                              d_acc_q[3:0], p_acc_q[3:0]});
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any audit in flight.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) hex_q[i] <= '0;
      ledr_q  <= '0;
      idx_q   <= '0;
      p_acc_q <= '0;
      d_acc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ps_q    <= '0;
      ds_q    <= '0;
      pw_q    <= 1'b0;
      dw_q    <= 1'b0;
      mm_q    <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      hex_q   <= hex_d;
      ledr_q  <= ledr_d;
      idx_q   <= idx_d;
      p_acc_q <= p_acc_d;
      d_acc_q <= d_acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ps_q    <= ps_d;
      ds_q    <= ds_d;
      pw_q    <= pw_d;
      dw_q    <= dw_d;
      mm_q    <= mm_d;
      mask_q  <= mask_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign player_score = ps_q;
  assign dealer_score = ds_q;
  assign player_win   = pw_q;
  assign dealer_win   = dw_q;
  assign invalid_mask = mask_q;
  assign mismatch     = mm_q;

endmodule

// File: tb/tb_hand_display_auditor.sv
// Directed self-checking bench for hand_display_auditor with a result scoreboard.
module tb_hand_display_auditor;
  import card_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [6:0] h0, h1, h2, h3, h4, h5;
  logic [9:0] ledr;
  logic       busy, done, pw, dw, mm;
  logic [3:0] ps, ds;
  logic [5:0] mask;

  typedef struct packed {
    logic [3:0] ps;
    logic [3:0] ds;
    logic       pw;
    logic       dw;
    logic [5:0] mask;
    logic       mm;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hand_display_auditor #(.NUM_DIGITS(6)) dut (
    .CLOCK_50     (clk),
    .reset        (rst),
    .start        (start),
    .HEX0         (h0),
    .HEX1         (h1),
    .HEX2         (h2),
    .HEX3         (h3),
    .HEX4         (h4),
    .HEX5         (h5),
    .LEDR_in      (ledr),
    .busy         (busy),
    .done         (done),
    .player_score (ps),
    .dealer_score (ds),
    .player_win   (pw),
    .dealer_win   (dw),
    .invalid_mask (mask),
    .mismatch     (mm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_hex(input logic [6:0] a, b, c, d, e, f);
    h0 = a; h1 = b; h2 = c; h3 = d; h4 = e; h5 = f;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_ps"},   32'(ps),   0);
    check({tag, "_ds"},   32'(ds),   0);
    check({tag, "_pw"},   32'(pw),   0);
    check({tag, "_dw"},   32'(dw),   0);
    check({tag, "_mask"}, 32'(mask), 0);
    check({tag, "_mm"},   32'(mm),   0);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_ps"},   32'(ps),   32'(e.ps));
      check({tag, "_ds"},   32'(ds),   32'(e.ds));
      check({tag, "_pw"},   32'(pw),   32'(e.pw));
      check({tag, "_dw"},   32'(dw),   32'(e.dw));
      check({tag, "_mask"}, 32'(mask), 32'(e.mask));
      check({tag, "_mm"},   32'(mm),   32'(e.mm));
    end
  endtask

  // One start pulse; optionally poke start mid-audit or scramble inputs after capture.
  task automatic run_audit(input string tag, input exp_t e, input bit poke_busy, input bit scramble);
    int lat;
    int extra;
    sb.push_back(e);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        check({tag, "_busy_set"}, 32'(busy), 1);
        if (scramble) begin
          set_hex(7'b1010101, SEG_KING, SEG_KING, 7'b0101010, SEG_ACE, SEG_ACE);
          ledr = ~ledr;
        end
      end
      if (poke_busy && k == 3) start = 1'b1;
      if (poke_busy && k == 4) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 8);
    if (lat >= 0) begin
      compare_result(tag);
      check({tag, "_busy_clr"}, 32'(busy), 0);
    end else begin
      void'(sb.pop_front());
    end
    if (poke_busy) begin
      extra = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check({tag, "_no_extra_done"}, 32'(extra), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int t_first;
    int t_second;
    int spurious;
    int third;

    rst = 1'b1; start = 1'b0; ledr = '0;
    set_hex(SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK);
    @(negedge clk);
    check_zero("reset");
    @(negedge clk); rst = 1'b0;

    // Nominal hand, with a start poke while busy.
    set_hex(SEG_ACE, SEG_FIVE, SEG_BLANK, SEG_THREE, SEG_SEVEN, SEG_NINE);
    ledr = 10'b10_1001_0110;
    run_audit("nominal", '{ps:4'd6, ds:4'd9, pw:1'b0, dw:1'b1, mask:6'b0, mm:1'b0}, 1'b1, 1'b0);

    // Wrong player score on LEDR; inputs scrambled after capture.
    set_hex(SEG_ACE, SEG_FIVE, SEG_BLANK, SEG_THREE, SEG_SEVEN, SEG_NINE);
    ledr = 10'b10_1001_0111;
    run_audit("mismatch", '{ps:4'd6, ds:4'd9, pw:1'b0, dw:1'b1, mask:6'b0, mm:1'b1}, 1'b0, 1'b1);

    // Tie on face cards.
    set_hex(SEG_KING, SEG_QUEEN, SEG_BLANK, SEG_JACK, SEG_TEN, SEG_BLANK);
    ledr = 10'b11_0000_0000;
    run_audit("tie", '{ps:4'd0, ds:4'd0, pw:1'b1, dw:1'b1, mask:6'b0, mm:1'b0}, 1'b0, 1'b0);

    // Maximum sums 27 and 24.
    set_hex(SEG_NINE, SEG_NINE, SEG_NINE, SEG_EIGHT, SEG_EIGHT, SEG_EIGHT);
    ledr = 10'b01_0100_0111;
    run_audit("maxsum", '{ps:4'd7, ds:4'd4, pw:1'b1, dw:1'b0, mask:6'b0, mm:1'b0}, 1'b0, 1'b0);

    // Illegal pattern on HEX1 and blank on HEX3.
    set_hex(SEG_ACE, 7'b1010101, SEG_BLANK, SEG_BLANK, SEG_SEVEN, SEG_NINE);
    ledr = 10'b10_0110_0001;
    run_audit("illegal", '{ps:4'd1, ds:4'd6, pw:1'b0, dw:1'b1, mask:6'b001010, mm:1'b0}, 1'b0, 1'b0);

    // start held high: two pulses in 20 cycles, 9 apart, third follows.
    set_hex(SEG_ACE, SEG_FIVE, SEG_BLANK, SEG_THREE, SEG_SEVEN, SEG_NINE);
    ledr = 10'b10_1001_0110;
    for (int i = 0; i < 3; i++)
      sb.push_back('{ps:4'd6, ds:4'd9, pw:1'b0, dw:1'b1, mask:6'b0, mm:1'b0});
    pulses = 0; t_first = -1; t_second = -1; third = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 19) start = 1'b0;
      if (done) begin
        compare_result("b2b");
        if (k < 20) begin
          pulses++;
          if (t_first < 0) t_first = k;
          else             t_second = k;
        end else begin
          third++;
        end
      end
    end
    check("b2b_pulses", 32'(pulses), 2);
    check("b2b_gap", 32'(t_second - t_first), 9);
    check("b2b_third", 32'(third), 1);

    // Reset during the 4th DECODE cycle aborts the audit.
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk); rst = 1'b0;
    spurious = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    check("midreset_no_done", 32'(spurious), 0);

    // Normal audit after the abort.
    run_audit("post_reset", '{ps:4'd6, ds:4'd9, pw:1'b0, dw:1'b1, mask:6'b0, mm:1'b0}, 1'b0, 1'b0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
